// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker
// Holds the hazard-relevant slice of a 5-stage pipeline: D-stage valid plus
// the ID/EX, EX/MEM and MEM/WB register-address and control fields that the
// hazard unit inspects. It also applies the stall/flush controls that the
// hazard unit returns. Bubbles are zeroed fields, so an empty stage never
// looks like a register writer. Three saturating counters track stall
// cycles, flush cycles and retired instructions. All outputs are registered.

module hazard_pipe_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_f,
    input  logic [REG_AW-1:0] RS1_d,
    input  logic [REG_AW-1:0] RS2_d,
    input  logic [REG_AW-1:0] RD_d,
    input  logic              RegWrite_d,
    input  logic [1:0]        ResultSrc_d,
    input  logic              Stall_d,
    input  logic              Flush_d,
    input  logic              Flush_e,
    input  logic              cnt_clr,
    output logic              valid_d,
    output logic [REG_AW-1:0] RS1_e,
    output logic [REG_AW-1:0] RS2_e,
    output logic [REG_AW-1:0] RD_e,
    output logic              RegWrite_e,
    output logic [1:0]        ResultSrc_e,
    output logic [REG_AW-1:0] RD_m,
    output logic              RegWrite_m,
    output logic [REG_AW-1:0] RD_w,
    output logic              RegWrite_w,
    output logic              valid_e,
    output logic              valid_m,
    output logic              valid_w,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // D stage
    logic              valid_d_q, valid_d_d;

    // E stage
    logic              valid_e_q, valid_e_d;
    logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
    logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
    logic [REG_AW-1:0] rd_e_q, rd_e_d;
    logic              regwrite_e_q, regwrite_e_d;
    logic [1:0]        resultsrc_e_q, resultsrc_e_d;

    // M and W stages
    logic              valid_m_q, regwrite_m_q;
    logic [REG_AW-1:0] rd_m_q;
    logic              valid_w_q, regwrite_w_q;
    logic [REG_AW-1:0] rd_w_q;

    // Performance counters
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    // Clear beats increment; an increment stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != CNT_MAX)) begin
            nxt = cur + CNT_ONE;
        end
        return nxt;
    endfunction

    // D-stage occupancy: flush wins over stall, stall holds, otherwise load fetch.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves it unassigned and no latch is inferred.
        valid_d_d = valid_f;
        if (Flush_d) begin
            valid_d_d = 1'b0;
        end else if (Stall_d) begin
            valid_d_d = valid_d_q;
        end
    end

    // E-stage capture: bubble on flush or an empty D stage, else copy decode fields.
    always_comb begin
        valid_e_d     = 1'b0;
        rs1_e_d       = '0;
        rs2_e_d       = '0;
        rd_e_d        = '0;
        regwrite_e_d  = 1'b0;
        resultsrc_e_d = 2'b00;
        if (!Flush_e && valid_d_q) begin
            valid_e_d     = 1'b1;
            rs1_e_d       = RS1_d;
            rs2_e_d       = RS2_d;
            rd_e_d        = RD_d;
            regwrite_e_d  = RegWrite_d;
            resultsrc_e_d = ResultSrc_d;
        end
    end

    // Counter next-state; qualifiers use this cycle's inputs and current W occupancy.
    always_comb begin
        stall_cnt_d  = cnt_next(stall_cnt_q, Stall_d & ~Flush_d, cnt_clr);
        flush_cnt_d  = cnt_next(flush_cnt_q, Flush_d, cnt_clr);
        retire_cnt_d = cnt_next(retire_cnt_q, valid_w_q, cnt_clr);
    end

    // Pipeline and counter registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d_q     <= 1'b0;
            valid_e_q     <= 1'b0;
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            rd_e_q        <= '0;
            regwrite_e_q  <= 1'b0;
            resultsrc_e_q <= 2'b00;
            valid_m_q     <= 1'b0;
            rd_m_q        <= '0;
            regwrite_m_q  <= 1'b0;
            valid_w_q     <= 1'b0;
            rd_w_q        <= '0;
            regwrite_w_q  <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            retire_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let M read the old E and W read
            // the old M on the same edge, which is what makes this a shift.
            valid_d_q     <= valid_d_d;
            valid_e_q     <= valid_e_d;
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            regwrite_e_q  <= regwrite_e_d;
            resultsrc_e_q <= resultsrc_e_d;
            valid_m_q     <= valid_e_q;
            rd_m_q        <= rd_e_q;
            regwrite_m_q  <= regwrite_e_q;
            valid_w_q     <= valid_m_q;
            rd_w_q        <= rd_m_q;
            regwrite_w_q  <= regwrite_m_q;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign valid_d     = valid_d_q;
    assign valid_e     = valid_e_q;
    assign RS1_e       = rs1_e_q;
    assign RS2_e       = rs2_e_q;
    assign RD_e        = rd_e_q;
    assign RegWrite_e  = regwrite_e_q;
    assign ResultSrc_e = resultsrc_e_q;
    assign valid_m     = valid_m_q;
    assign RD_m        = rd_m_q;
    assign RegWrite_m  = regwrite_m_q;
    assign valid_w     = valid_w_q;
    assign RD_w        = rd_w_q;
    assign RegWrite_w  = regwrite_w_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Testbench for hazard_pipe_tracker.
// The stimulus drives directed vectors and, for each one, queues the hand-computed
// values that must appear on a given future cycle. A separate monitor compares the
// queued values on the falling edge of the cycle they target. Asynchronous reset
// behaviour between edges is checked directly at the instant of interest.

module tb_hazard_pipe_tracker;

    localparam int REG_AW = 5;

    typedef enum int {
        S_VALID_D, S_RS1_E, S_RS2_E, S_RD_E, S_RW_E, S_RSRC_E, S_VALID_E,
        S_RD_M, S_RW_M, S_VALID_M, S_RD_W, S_RW_W, S_VALID_W,
        S_STALL, S_FLUSH, S_RETIRE, S_SAT, S_NUM
    } sel_e;

    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic valid_f, RegWrite_d, Stall_d, Flush_d, Flush_e, cnt_clr;
    logic [REG_AW-1:0] RS1_d, RS2_d, RD_d;
    logic [1:0] ResultSrc_d;

    logic valid_d, RegWrite_e, RegWrite_m, RegWrite_w, valid_e, valid_m, valid_w;
    logic [REG_AW-1:0] RS1_e, RS2_e, RD_e, RD_m, RD_w;
    logic [1:0] ResultSrc_e;
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;

    // Narrow-counter instance: only its stall and clear inputs are exercised.
    logic sat_stall, sat_clr;
    logic zero1;
    logic [REG_AW-1:0] zero_a;
    logic [1:0] zero2;
    logic sat_valid_d, sat_rw_e, sat_rw_m, sat_rw_w, sat_valid_e, sat_valid_m, sat_valid_w;
    logic [REG_AW-1:0] sat_rs1_e, sat_rs2_e, sat_rd_e, sat_rd_m, sat_rd_w;
    logic [1:0] sat_rsrc_e;
    logic [3:0] sat_stall_cnt, sat_flush_cnt, sat_retire_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hazard_pipe_tracker #(.REG_AW(REG_AW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .valid_f(valid_f),
        .RS1_d(RS1_d), .RS2_d(RS2_d), .RD_d(RD_d),
        .RegWrite_d(RegWrite_d), .ResultSrc_d(ResultSrc_d),
        .Stall_d(Stall_d), .Flush_d(Flush_d), .Flush_e(Flush_e), .cnt_clr(cnt_clr),
        .valid_d(valid_d), .RS1_e(RS1_e), .RS2_e(RS2_e), .RD_e(RD_e),
        .RegWrite_e(RegWrite_e), .ResultSrc_e(ResultSrc_e),
        .RD_m(RD_m), .RegWrite_m(RegWrite_m), .RD_w(RD_w), .RegWrite_w(RegWrite_w),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    hazard_pipe_tracker #(.REG_AW(REG_AW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .valid_f(zero1),
        .RS1_d(zero_a), .RS2_d(zero_a), .RD_d(zero_a),
        .RegWrite_d(zero1), .ResultSrc_d(zero2),
        .Stall_d(sat_stall), .Flush_d(zero1), .Flush_e(zero1), .cnt_clr(sat_clr),
        .valid_d(sat_valid_d), .RS1_e(sat_rs1_e), .RS2_e(sat_rs2_e), .RD_e(sat_rd_e),
        .RegWrite_e(sat_rw_e), .ResultSrc_e(sat_rsrc_e),
        .RD_m(sat_rd_m), .RegWrite_m(sat_rw_m), .RD_w(sat_rd_w), .RegWrite_w(sat_rw_w),
        .valid_e(sat_valid_e), .valid_m(sat_valid_m), .valid_w(sat_valid_w),
        .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt), .retire_cnt(sat_retire_cnt)
    );

    function automatic logic [31:0] get_sig(input sel_e s);
        logic [31:0] r;
        r = '0;
        case (s)
            S_VALID_D: r = {31'b0, valid_d};
            S_RS1_E:   r = {27'b0, RS1_e};
            S_RS2_E:   r = {27'b0, RS2_e};
            S_RD_E:    r = {27'b0, RD_e};
            S_RW_E:    r = {31'b0, RegWrite_e};
            S_RSRC_E:  r = {30'b0, ResultSrc_e};
            S_VALID_E: r = {31'b0, valid_e};
            S_RD_M:    r = {27'b0, RD_m};
            S_RW_M:    r = {31'b0, RegWrite_m};
            S_VALID_M: r = {31'b0, valid_m};
            S_RD_W:    r = {27'b0, RD_w};
            S_RW_W:    r = {31'b0, RegWrite_w};
            S_VALID_W: r = {31'b0, valid_w};
            S_STALL:   r = stall_cnt;
            S_FLUSH:   r = flush_cnt;
            S_RETIRE:  r = retire_cnt;
            S_SAT:     r = {28'b0, sat_stall_cnt};
            default:   r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < int'(S_NUM); i++) begin
            sel_e s;
            s = sel_e'(i);
            check($sformatf("%s %s", tag, s.name()), get_sig(s), 32'd0);
        end
    endtask

    // Queue a required value for the cycle k edges after the current one.
    task automatic expect_at(input int k, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + k;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic vf, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                         input logic st, input logic fd, input logic fe);
        valid_f     = vf;
        RS1_d       = rs1;
        RS2_d       = rs2;
        RD_d        = rd;
        RegWrite_d  = rw;
        ResultSrc_d = rsrc;
        Stall_d     = st;
        Flush_d     = fd;
        Flush_e     = fe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare every queued value whose target cycle is the current one.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("cyc%0d %s", cyc, sb[i].sel.name()), get_sig(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cnt_clr = 1'b0;
        sat_stall = 1'b0;
        sat_clr = 1'b0;
        zero1 = 1'b0;
        zero_a = '0;
        zero2 = 2'b00;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        idle(1);

        // Straight-line flow: valid fetch, then decode rd=5 writing.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_at(1, S_VALID_D, 1);
        expect_at(1, S_VALID_E, 0);
        tick();
        drive(0, 1, 2, 5, 1, 0, 0, 0, 0);
        expect_at(1, S_RD_E, 5);
        expect_at(1, S_RS1_E, 1);
        expect_at(1, S_RS2_E, 2);
        expect_at(1, S_RW_E, 1);
        expect_at(1, S_VALID_E, 1);
        expect_at(1, S_VALID_D, 0);
        expect_at(2, S_RD_M, 5);
        expect_at(2, S_RW_M, 1);
        expect_at(2, S_RD_E, 0);
        expect_at(3, S_RD_W, 5);
        expect_at(3, S_RW_W, 1);
        expect_at(3, S_VALID_W, 1);
        expect_at(4, S_RETIRE, 1);
        tick();
        idle(4);

        // Load-use stall: load rd=3 enters E, consumer rs1=3 waits one cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 4, 6, 3, 1, 2'b01, 0, 0, 0);
        expect_at(1, S_RD_E, 3);
        expect_at(1, S_RSRC_E, 1);
        expect_at(1, S_RW_E, 1);
        tick();
        drive(0, 3, 7, 8, 1, 0, 1, 0, 1);
        expect_at(1, S_VALID_D, 1);
        expect_at(1, S_VALID_E, 0);
        expect_at(1, S_RD_E, 0);
        expect_at(1, S_RS1_E, 0);
        expect_at(1, S_RW_E, 0);
        expect_at(1, S_RSRC_E, 0);
        expect_at(1, S_RD_M, 3);
        expect_at(1, S_RW_M, 1);
        expect_at(1, S_STALL, 1);
        tick();
        drive(0, 3, 7, 8, 1, 0, 0, 0, 0);
        expect_at(1, S_RD_E, 8);
        expect_at(1, S_RS1_E, 3);
        expect_at(1, S_RS2_E, 7);
        expect_at(1, S_VALID_D, 0);
        expect_at(1, S_STALL, 1);
        expect_at(1, S_RD_W, 3);
        expect_at(2, S_RD_M, 8);
        expect_at(2, S_RETIRE, 2);
        expect_at(3, S_RD_W, 8);
        expect_at(4, S_RETIRE, 3);
        tick();
        idle(4);

        // Branch flush with a live instruction in E: two bubbles follow it to W.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
        expect_at(1, S_RD_E, 9);
        expect_at(1, S_VALID_E, 1);
        tick();
        drive(1, 0, 0, 10, 1, 0, 0, 1, 1);
        expect_at(1, S_VALID_D, 0);
        expect_at(1, S_VALID_E, 0);
        expect_at(1, S_RD_E, 0);
        expect_at(1, S_FLUSH, 1);
        expect_at(1, S_RD_M, 9);
        expect_at(2, S_RD_W, 9);
        expect_at(2, S_RW_W, 1);
        expect_at(3, S_RW_W, 0);
        expect_at(3, S_VALID_W, 0);
        expect_at(3, S_RD_W, 0);
        expect_at(3, S_RETIRE, 4);
        expect_at(4, S_RW_W, 0);
        expect_at(4, S_VALID_W, 0);
        expect_at(4, S_RETIRE, 4);
        expect_at(4, S_STALL, 1);
        tick();
        idle(4);

        // Stall and flush together: flush wins, only flush counter moves.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 12, 1, 0, 1, 1, 0);
        expect_at(1, S_VALID_D, 0);
        expect_at(1, S_STALL, 1);
        expect_at(1, S_FLUSH, 2);
        expect_at(1, S_RD_E, 12);
        expect_at(1, S_VALID_E, 1);
        tick();
        idle(4);

        // 4-bit stall counter: saturate at 15, then clear overrides an increment.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sat_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)  expect_at(1, S_SAT, 1);
            if (i == 13) expect_at(1, S_SAT, 14);
            if (i == 14) expect_at(1, S_SAT, 15);
            if (i == 15) expect_at(1, S_SAT, 15);
            if (i == 19) expect_at(1, S_SAT, 15);
            tick();
        end
        sat_clr = 1'b1;
        expect_at(1, S_SAT, 0);
        expect_at(1, S_FLUSH, 2);
        tick();
        sat_clr = 1'b0;
        expect_at(1, S_SAT, 1);
        tick();
        sat_stall = 1'b0;
        expect_at(1, S_SAT, 1);
        tick();
        idle(1);

        // Asynchronous reset between edges with three instructions in flight.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
        expect_at(0, S_RD_E, 2);
        expect_at(0, S_RD_M, 1);
        tick();
        check("pre_rst RD_w", {27'b0, RD_w}, 32'd1);
        check("pre_rst RD_m", {27'b0, RD_m}, 32'd2);
        check("pre_rst RD_e", {27'b0, RD_e}, 32'd3);
        check("pre_rst valid_d", {31'b0, valid_d}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #4;
        rst = 1'b0;
        #1;
        check("post_release valid_d", {31'b0, valid_d}, 32'd0);
        tick();
        check("first_edge valid_d", {31'b0, valid_d}, 32'd1);
        check("first_edge valid_e", {31'b0, valid_e}, 32'd0);
        idle(3);

        for (int i = 0; i < sb.size(); i++) begin
            n_checks++;
            n_errors++;
            $display("FAIL unchecked %s: target cycle %0d, expected 0x%0h", sb[i].sel.name(), sb[i].cyc, sb[i].val);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
